// File: rtl/rr_dispatcher_pkg.sv
// Shared constants for the round-robin write dispatcher and its channel FIFOs.
package rr_dispatcher_pkg;
   localparam int NCH = 4;
   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 8;
endpackage

// File: rtl/dispatch_fifo.sv
// Single-clock channel FIFO with registered read data (1-cycle latency).
// Reads on empty raise rerr; writes while full are refused, using the pre-edge count.
module dispatch_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wen,
   input  logic          ren,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          rvalid,
   output logic          rerr,
   output logic          full,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == CW'(DEPTH));
   assign do_wr = wen & ~full;
   assign do_rd = ren & (count != '0);

   always_ff @(posedge clk) begin
      if (!rst && do_wr) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
         rvalid <= 1'b0;
         rerr   <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         // Read and write in the same cycle cancel out in the count.
         count  <= count + CW'(do_wr) - CW'(do_rd);
         dout   <= do_rd ? mem[rd_ptr] : '0;
         rvalid <= do_rd;
         rerr   <= ren & ~do_rd;
      end
   end
endmodule

// File: rtl/rr_dispatcher.sv
// Distributes one input stream round-robin over four channel FIFOs, skipping full ones.
// in_ready drops only when every channel is full; a word offered then is dropped and flagged on ovf.
module rr_dispatcher
   import rr_dispatcher_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DW-1:0]     din,
   output logic              in_ready,
   output logic              ovf,
   input  logic [NCH-1:0]    ren,
   output logic [NCH*DW-1:0] dout,
   output logic [NCH-1:0]    out_valid,
   output logic [NCH-1:0]    err
);
   logic [1:0]     ptr;
   logic [1:0]     sel;
   logic [1:0]     cand;
   logic           found;
   logic           accept;
   logic [NCH-1:0] full;
   logic [NCH-1:0] wen;
   logic [CW-1:0]  count [NCH];

   // Priority search starting at ptr, wrapping modulo the channel count.
   always_comb begin
      sel   = ptr;
      cand  = ptr;
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         cand = ptr + 2'(k);
         if (!found && (count[cand] < CW'(DEPTH))) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   assign in_ready = ~&full;
   assign accept   = in_valid & in_ready;
   assign wen      = accept ? (NCH'(1) << sel) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= CH_A;
         ovf <= 1'b0;
      end else begin
         ovf <= in_valid & ~in_ready;
         if (accept) ptr <= sel + 2'd1;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      dispatch_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH),
         .CW    (CW)
      ) u_fifo (
         .clk    (clk),
         .rst    (rst),
         .wen    (wen[i]),
         .ren    (ren[i]),
         .din    (din),
         .dout   (dout[DW*i +: DW]),
         .rvalid (out_valid[i]),
         .rerr   (err[i]),
         .full   (full[i]),
         .count  (count[i])
      );
   end
endmodule

// File: tb/tb_rr_dispatcher.sv
// Scoreboard bench for rr_dispatcher: queue-based reference model, directed scenarios then random traffic.
module tb_rr_dispatcher;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  din = '0;
   logic        in_ready;
   logic        ovf;
   logic [3:0]  ren = '0;
   logic [31:0] dout;
   logic [3:0]  out_valid;
   logic [3:0]  err;

   rr_dispatcher dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .din       (din),
      .in_ready  (in_ready),
      .ovf       (ovf),
      .ren       (ren),
      .dout      (dout),
      .out_valid (out_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  er;
      logic [31:0] dat;
      logic        ov;
   } cyc_t;

   cyc_t       expq[$];
   logic [7:0] mq[4][$];
   int         mptr = 0;
   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected record per clock edge.
   initial begin
      cyc_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.vld));
            chk("err", 32'(err), 32'(e.er));
            chk("dout", dout, e.dat);
            chk("ovf", 32'(ovf), 32'(e.ov));
         end
      end
   end

   task automatic do_reset();
      cyc_t e;
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'($urandom);
      din = 8'($urandom);
      ren = 4'($urandom);
      for (int c = 0; c < 4; c++) mq[c].delete();
      mptr = 0;
      e.vld = '0; e.er = '0; e.dat = '0; e.ov = 1'b0;
      expq.push_back(e);
   endtask

   task automatic step(input bit iv, input logic [7:0] d, input logic [3:0] r);
      cyc_t e;
      int   s;
      bit   exp_rdy;
      @(negedge clk);
      rst = 1'b0;
      in_valid = iv;
      din = d;
      ren = r;
      #1;
      exp_rdy = 1'b0;
      for (int c = 0; c < 4; c++) if (mq[c].size() < DEPTH) exp_rdy = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      // Target chosen from the pre-edge occupancy, before this cycle's reads.
      s = -1;
      for (int k = 0; k < 4; k++)
         if (s < 0 && mq[(mptr + k) % 4].size() < DEPTH) s = (mptr + k) % 4;
      e.vld = '0; e.er = '0; e.dat = '0; e.ov = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (r[c]) begin
            if (mq[c].size() > 0) begin
               e.vld[c] = 1'b1;
               e.dat[8*c +: 8] = mq[c].pop_front();
            end else begin
               e.er[c] = 1'b1;
            end
         end
      end
      if (iv) begin
         if (s >= 0) begin
            mq[s].push_back(d);
            mptr = (s + 1) % 4;
         end else begin
            e.ov = 1'b1;
         end
      end
      expq.push_back(e);
   endtask

   task automatic drain();
      for (int n = 0; n < DEPTH + 1; n++) step(1'b0, 8'h00, 4'hF);
   endtask

   initial begin
      bit         iv;
      logic [3:0] r;
      int         rate;

      // Eight words spread 0,1,2,3,0,1,2,3 then read back, plus empty reads.
      do_reset();
      for (int n = 0; n < 8; n++) step(1'b1, 8'h10 + 8'(n), 4'h0);
      step(1'b0, 8'h00, 4'hF);
      step(1'b0, 8'h00, 4'hF);
      step(1'b0, 8'h00, 4'hF);
      step(1'b0, 8'h00, 4'b0001);

      // Channel 1 full alone with ptr=1: next word must skip to channel 2.
      do_reset();
      step(1'b1, 8'h01, 4'h0);
      step(1'b0, 8'h00, 4'b0001);
      for (int n = 0; n < 32; n++) step(1'b1, 8'(n + 8'h40), 4'h0);
      for (int n = 0; n < 8; n++) step(1'b0, 8'h00, 4'b1101);
      step(1'b1, 8'hAA, 4'h0);
      step(1'b1, 8'hAB, 4'h0);
      drain();

      // All full: word dropped, ovf pulse, nothing extra stored.
      do_reset();
      for (int n = 0; n < 32; n++) step(1'b1, 8'(n + 8'h80), 4'h0);
      step(1'b1, 8'h55, 4'h0);
      step(1'b0, 8'h00, 4'h0);
      drain();

      // Channel 0 holds 0x11 then 0x22; three consecutive reads.
      do_reset();
      step(1'b1, 8'h11, 4'h0);
      step(1'b1, 8'hB1, 4'h0);
      step(1'b1, 8'hB2, 4'h0);
      step(1'b1, 8'hB3, 4'h0);
      step(1'b1, 8'h22, 4'h0);
      for (int n = 0; n < 3; n++) step(1'b0, 8'h00, 4'b0001);

      // Channel 3 full at ptr=3, concurrent write and read of channel 3, then reset.
      do_reset();
      for (int n = 0; n < 32; n++) step(1'b1, 8'(n + 8'hC0), 4'h0);
      step(1'b0, 8'h00, 4'b0101);
      step(1'b1, 8'hE0, 4'h0);
      step(1'b1, 8'hE1, 4'h0);
      step(1'b0, 8'h00, 4'b0001);
      step(1'b1, 8'h77, 4'b1000);
      step(1'b0, 8'h00, 4'h0);
      do_reset();
      step(1'b1, 8'h99, 4'hF);
      step(1'b1, 8'h9A, 4'h0);
      drain();

      // Random traffic alternating between filling and draining phases.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rate = ((n / 150) % 2 == 0) ? 7 : 1;
         iv = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < 4; c++) r[c] = ($urandom_range(0, rate) == 0);
         step(iv, 8'($urandom), r);
         if (n == 1700) do_reset();
      end
      drain();

      @(negedge clk);
      in_valid = 1'b0;
      ren = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_empty", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rr_dispatcher.md
Name: rr_dispatcher

Overview:
- Write-side counterpart of the 4-channel round-robin read arbiter. Takes one 8-bit input stream and distributes words round-robin into four per-channel FIFOs, each drained independently by its own consumer.
- Sits between a single producer (packet source or UART RX) and four downstream lanes.
- Full channels are skipped, so no input word is lost while any channel has space.

Parameters:
- DW, 8, data width of input word and each channel output
- DEPTH, 8, entries per channel FIFO (power of 2, ≥2)
- CW, 4, count width, log2(DEPTH)+1

Ports:
- clk  in  1  single clock, all logic posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer presents din this cycle
- din  in  DW  input word
- in_ready  out  1  combinational, 1 when at least one channel FIFO is not full
- ovf  out  1  registered pulse, 1 cycle after in_valid=1 while in_ready=0 (word dropped)
- ren  in  4  per-channel read enable, bit i = channel i (a,b,c,d = 0..3)
- dout  out  4*DW  channel i data on bits [DW*i+DW-1 : DW*i]
- out_valid  out  4  registered, bit i=1 the cycle after a successful read of channel i
- err  out  4  registered, bit i=1 the cycle after ren[i] while channel i was empty

Behaviour:
- Reset (rst=1 at posedge):
  - ptr=0; all FIFO counts, read pointers and write pointers = 0
  - dout=0, out_valid=0, err=0, ovf=0
  - storage contents are don't-care
  - in_valid and ren are ignored that cycle
- Rotation pointer ptr[1:0] names the next channel to receive a word.
- Select (combinational, on registered counts):
  - sel = first channel i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with count_i < DEPTH
  - in_ready = OR over i of (count_i < DEPTH)
- Accept (in_valid & in_ready at posedge):
  - din is written to FIFO[sel]; count_sel increments
  - ptr <= sel+1 (mod 4), so a skipped full channel is not retried before the rotation returns to it
- Drop (in_valid & !in_ready): nothing is written, ptr is unchanged, ovf=1 the next cycle.
- No input word: ptr holds.
- Read on channel i (ren[i]) at posedge:
  - If count_i>0: dout_i <= head word, out_valid[i] <= 1, err[i] <= 0, count decrements, read pointer advances.
  - If count_i==0: dout_i <= 0, out_valid[i] <= 0, err[i] <= 1.
  - Read latency is 1 cycle.
- ren[i]=0: dout_i <= 0, out_valid[i] <= 0, err[i] <= 0.
- Simultaneous read and write on the same channel: full and empty tests use the pre-edge count.
  - Full channel plus read: the write is refused (channel excluded from sel) and the read succeeds.
  - Empty channel plus write: the read errs and the write lands; count ends at 1.
  - Non-full, non-empty channel plus both: count is unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
- Channels are independent; reads on any subset of channels may occur in the same cycle.
- Reset mid-stream: all buffered data is discarded. The first word after reset goes to channel 0.

Decomposition:
- Shared package holds:
  - NCH=4
  - channel index constants CH_A..CH_D
  - DW and DEPTH defaults
- Sub-module dispatch_fifo, instantiated 4×. Ports: clk, rst, wen, ren, din, dout, rvalid, rerr, full, count. Single-clock synchronous FIFO.
- The top level holds ptr, the priority-rotate select, ovf, and the dout packing.

Test Plan:
- rst=1 then 8 consecutive accepts 0x10..0x17, no reads -> words land in channels 0,1,2,3,0,1,2,3; each count=2; ptr=0.
- Channel 1 pre-filled to 8 (others empty, ptr=1), write 0xAA -> lands in channel 2; ptr=3; in_ready stays 1.
- All four channels full, in_valid=1 din=0x55 -> in_ready=0; ovf=1 next cycle; counts unchanged; ptr unchanged.
- ren=4'b0001 on empty channel 0 -> next cycle err=4'b0001, out_valid=0, dout[7:0]=0x00.
- Channel 0 holds 0x11,0x22; ren[0]=1 for 3 cycles -> out_valid[0] 1,1,0 with dout 0x11, 0x22, 0x00; err[0] on 3rd cycle only.
- Channel 3 full, ptr=3, same cycle in_valid=1 (0x77) and ren[3]=1 -> read returns channel 3 head; 0x77 goes to channel 0; rst=1 afterwards clears all counts, outputs 0, ptr=0.
